// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: the FSM state and the grant identity.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;

    function automatic grant_t otherGrant(input grant_t g);
        return (g == GNT_I) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a tie goes to whoever was not served last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        grant = GNT_I;
        if (req_i && req_d) begin
            grant = otherGrant(grant_t'(last_grant));
        end else if (req_d) begin
            grant = GNT_D;
        end
    end

    assign valid = req_i | req_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the icache and dcache controllers, one
// transaction at a time, with round-robin fairness and a no-ack timeout abort.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

    arb_state_t    stateReg;
    grant_t        lastGrant;
    grant_t        ownerReg;
    logic [TW-1:0] timerReg;
    logic [DW-1:0] capDataReg;

    logic   pickGrantBit;
    logic   pickValid;
    grant_t pickGrant;

    rr_pick2 uPick (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (lastGrant),
        .grant      (pickGrantBit),
        .valid      (pickValid)
    );

    assign pickGrant = grant_t'(pickGrantBit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            lastGrant  <= GNT_I;
            ownerReg   <= GNT_I;
            timerReg   <= '0;
            capDataReg <= '0;
            i_done     <= 1'b0;
            i_rdata    <= '0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_err    <= 1'b0;
        end else begin
            // Done, read data and error are pulses; they fall back to 0 unless set below.
            i_done  <= 1'b0;
            i_rdata <= '0;
            d_done  <= 1'b0;
            d_rdata <= '0;
            mem_err <= 1'b0;

            unique case (stateReg)
                IDLE: begin
                    if (pickValid) begin
                        ownerReg  <= pickGrant;
                        lastGrant <= pickGrant;
                        mem_req   <= 1'b1;
                        timerReg  <= '0;
                        stateReg  <= WAIT;
                        if (pickGrant == GNT_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
                    end
                end

                WAIT: begin
                    if (timerReg != TIMER_MAX) begin
                        timerReg <= timerReg + 1'b1;
                    end
                    // An ack on the expiry edge wins over the abort.
                    if (mem_ack) begin
                        capDataReg <= mem_we ? '0 : mem_rdata;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        stateReg   <= RESP;
                    end else if (timerReg == TIMER_LAST) begin
                        capDataReg <= '0;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_err    <= 1'b1;
                        stateReg   <= RESP;
                    end
                end

                RESP: begin
                    if (ownerReg == GNT_D) begin
                        d_done  <= 1'b1;
                        d_rdata <= capDataReg;
                    end else begin
                        i_done  <= 1'b1;
                        i_rdata <= capDataReg;
                    end
                    stateReg <= IDLE;
                end

                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule
